// File: rtl/ram_byte_loader.sv
// Byte-stream to RAM word loader: packs bytes little-endian into DATA_WIDTH words and writes consecutive addresses.
// Optional write-back verification is enabled with `define LOADER_VERIFY_EN.
module ram_byte_loader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   word_count,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     mem_wEn,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_dataIn,
   input  logic [DATA_WIDTH-1:0]    mem_dataOut,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [ADDRESS_WIDTH:0]   words_written
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
`ifdef LOADER_VERIFY_EN
      S_VREAD,
      S_VCHECK,
`endif
      S_DONE
   } state_t;

   state_t                   state, state_next;
   logic [ADDRESS_WIDTH-1:0] base_r;
   logic [ADDRESS_WIDTH:0]   count_r;
   logic [ADDRESS_WIDTH:0]   ww_r;
   logic [ADDRESS_WIDTH:0]   ww_inc;
   logic [IW-1:0]            idx_r;
   logic [DATA_WIDTH-1:0]    word_r;
   logic [DATA_WIDTH-1:0]    word_next;
   logic [ADDRESS_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0]    data_r;
   logic                     last_byte;

   always_comb begin
      word_next  = word_r;
      for (int unsigned k = 0; k < BPW; k++) begin
         if (idx_r == IW'(k))
            word_next[8*k +: 8] = byte_data;
      end
      last_byte  = (idx_r == IW'(BPW - 1));
      ww_inc     = ww_r + 1'b1;
      state_next = state;
      case (state)
         S_IDLE:
            if (start)
               state_next = (word_count != '0) ? S_COLLECT : S_DONE;
         S_COLLECT:
            if (byte_valid && last_byte)
               state_next = S_WRITE;
`ifdef LOADER_VERIFY_EN
         S_WRITE:  state_next = S_VREAD;
         S_VREAD:  state_next = S_VCHECK;
         // words_written already advanced when WRITE was left
         S_VCHECK: state_next = (ww_r == count_r) ? S_DONE : S_COLLECT;
`else
         S_WRITE:  state_next = (ww_inc == count_r) ? S_DONE : S_COLLECT;
`endif
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         base_r  <= '0;
         count_r <= '0;
         ww_r    <= '0;
         idx_r   <= '0;
         word_r  <= '0;
         addr_r  <= '0;
         data_r  <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE:
               if (start) begin
                  base_r  <= base_addr;
                  count_r <= word_count;
                  ww_r    <= '0;
                  idx_r   <= '0;
                  word_r  <= '0;
               end
            S_COLLECT:
               if (byte_valid) begin
                  word_r <= word_next;
                  idx_r  <= last_byte ? '0 : idx_r + 1'b1;
                  if (last_byte) begin
                     addr_r <= base_r + ww_r[ADDRESS_WIDTH-1:0];
                     data_r <= word_next;
                  end
               end
            S_WRITE:
               ww_r <= ww_inc;
            default: ;
         endcase
      end
   end

`ifdef LOADER_VERIFY_EN
   logic error_r;

   always_ff @(posedge clk) begin
      if (reset)
         error_r <= 1'b0;
      else if (state == S_IDLE && start)
         error_r <= 1'b0;
      else if (state == S_VCHECK && mem_dataOut != data_r)
         error_r <= 1'b1;
   end

   assign error = error_r;
`else
   logic unused_dataout;
   assign unused_dataout = ^mem_dataOut;
   assign error          = 1'b0;
`endif

   assign byte_ready    = (state == S_COLLECT);
   assign mem_wEn       = (state == S_WRITE);
   assign mem_addr      = addr_r;
   assign mem_dataIn    = data_r;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign words_written = ww_r;

endmodule
